jt5205_timing_mc: RTL and testbench
===================================

// Module: jt5205_timing_mc
// PURPOSE
//  Multi-channel, parametrised ADPCM sample-timing generator for CH independent JT5205 voices.
//  Divides the shared clock enable by a per-channel rate chosen by a 2-bit S-pin code.
//  Outputs per channel: sample strobes (normal and opposite phase), a 2x-rate strobe, and the VCK pin.
//  Adds over the single-channel timer:
//   - rate changes deferred to the period boundary (glitch-free);
//   - a global phase-resync input;
//   - a readback of the active rate.
// PARAMETERS
//  CH    2   number of independent channels (>=1)
//  CW    8   divider counter width
//  LIM0  95  S=0 period-1 in cen ticks (1 <= LIMx < 2**CW)
//  LIM1  63  S=1 period-1
//  LIM2  47  S=2 period-1; S=3 = channel stopped
// PORTS
//  clk      in   1     system clock; the only clock
//  rst_n    in   1     synchronous, active-low reset
//  cen      in   1     clock enable; all counting qualified by it
//  sync     in   1     one-clk pulse; restarts phase of every running channel
//  sel      in   2*CH  S-pin code per channel; ch i = sel[2i+1:2i]
//  sel_act  out  2*CH  S code currently in effect per channel
//  cen_lo   out  CH    sample-rate strobe, one clk wide
//  cenb_lo  out  CH    sample-rate strobe, opposite (half-period) phase
//  cen_mid  out  CH    cen_lo | cenb_lo
//  vclk_o   out  CH    VCK pin level, 50% duty for even periods
// BEHAVIOUR
//  Reset (rst_n low at posedge clk):
//   - cnt=0, vclk_o=0, pre=0, preb=0, pending=0;
//   - sel_act<=sel, so the reset value is the input code.
//   - Overrides sync and cen.
//  Strobe outputs, per channel:
//   - pre and preb are registered flags;
//   - cen_lo=pre&cen, cenb_lo=preb&cen, cen_mid=(pre|preb)&cen;
//   - so each strobe coincides with the cen tick following the counter event.
//  Per-channel lim = LIM[sel_act]; half = lim>>1.
//  Normal operation (cen=1, sel_act!=3):
//   - pre<=0 and preb<=0, then:
//   - cnt==lim: cnt<=0, pre<=1, vclk_o<=1, and apply any pending sel (sel_act<=sel, pending<=0);
//   - else cnt<=cnt+1;
//   - cnt==half: preb<=1, vclk_o<=0. Evaluated independently of the lim test.
//   - lim=1 gives half=0, so preb fires one tick after the wrap.
//  Rate change:
//   - sel!=sel_act while running sets pending, and sel_act holds until the wrap;
//   - no truncated or stretched period is ever produced.
//   - sel reverting to sel_act before the wrap clears pending.
//   - sel==3 is also deferred to the wrap, then the channel stops.
//  Stopped channel (sel_act==3):
//   - cnt=0, vclk_o=0, pre=preb=0, no strobes.
//   - On the first cen with sel!=3: sel_act<=sel, cnt<=0.
//   - First cen_lo after restart comes lim+1 cen ticks later.
//  sync=1 at posedge clk, independent of cen:
//   - every channel: cnt<=0, vclk_o<=0, pre<=0, preb<=0;
//   - pending sel applied immediately.
//   - sync with cen in the same cycle: sync wins; no increment that cycle.
//  Channel independence: channels share only clk, rst_n, cen and sync. Counters never interact.
//  cen=0: all state frozen and all strobes 0; a pending change waits.
// TESTING
//  1. CH=2, cen every clk, sel={2'd1,2'd0} -> ch0 cen_lo every 96 clks, ch1 every 64 clks; cenb_lo 48/32 clks after each cen_lo.
//  2. ch0 S=0, cen 1-in-4, sel ch0->2 at cnt=10 -> sel_act stays 0 until cnt=95 wrap. Next period is 48 ticks; no short period.
//  3. ch0 running S=1, sel->3 -> stops after the current wrap, vclk_o=0. sel->0 -> first cen_lo 96 ticks later.
//  4. Both channels mid-period, sync pulse -> both cnt=0 and vclk_o=0 next clk. Identical S codes give coincident cen_lo thereafter.
//  5. rst_n low mid-period with sel={2,1} -> all outputs 0, sel_act={2,1}. Counting resumes from 0 on release.
//  6. LIM0=1, cen every clk -> cen_lo and cenb_lo alternate every clk; cen_mid continuously high.

Source files
------------

// File: rtl/jt5205_timing_mc.sv
// Multi-channel JT5205 ADPCM sample-timing generator.
// Each channel divides the shared clock enable by a rate picked from its
// 2-bit S code and produces sample strobes plus the VCK pin level. Rate
// changes wait for the end of the current period so a period is never
// cut short or stretched. A sync pulse restarts the phase of every channel.
module jt5205_timing_mc #(
    parameter int CH   = 2,
    parameter int CW   = 8,
    parameter int LIM0 = 95,
    parameter int LIM1 = 63,
    parameter int LIM2 = 47
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic            sync,
    input  logic [2*CH-1:0] sel,
    output logic [2*CH-1:0] sel_act,
    output logic [CH-1:0]   cen_lo,
    output logic [CH-1:0]   cenb_lo,
    output logic [CH-1:0]   cen_mid,
    output logic [CH-1:0]   vclk_o
);

    // Terminal count (period minus one) for an S code; code 3 never counts.
    function automatic logic [CW-1:0] lim_of(input logic [1:0] code);
        case (code)
            2'd0:    return CW'(LIM0);
            2'd1:    return CW'(LIM1);
            default: return CW'(LIM2);
        endcase
    endfunction

    genvar i;
    generate
        for (i = 0; i < CH; i++) begin : g_ch
            logic [CW-1:0] cnt;
            logic [CW-1:0] lim;
            logic [CW-1:0] half;
            logic [1:0]    act;
            logic [1:0]    s_in;
            logic          pre;
            logic          preb;
            logic          pending;
            logic          vclk;

            assign s_in = sel[2*i +: 2];
            assign lim  = lim_of(act);
            assign half = lim >> 1;

            // Divider, strobe flags, VCK level and deferred rate selection.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt     <= '0;
                    vclk    <= 1'b0;
                    pre     <= 1'b0;
                    preb    <= 1'b0;
                    pending <= 1'b0;
                    act     <= s_in;
                end else if (sync) begin
                    cnt     <= '0;
                    vclk    <= 1'b0;
                    pre     <= 1'b0;
                    preb    <= 1'b0;
                    pending <= 1'b0;
                    if (pending) begin
                        act <= s_in;
                    end
                end else if (cen) begin
                    pre  <= 1'b0;
                    preb <= 1'b0;
                    if (act == 2'd3) begin
                        cnt     <= '0;
                        vclk    <= 1'b0;
                        pending <= 1'b0;
                        if (s_in != 2'd3) begin
                            act <= s_in;
                        end
                    end else begin
                        if (cnt == lim) begin
                            cnt     <= '0;
                            pre     <= 1'b1;
                            vclk    <= 1'b1;
                            act     <= s_in;
                            pending <= 1'b0;
                        end else begin
                            cnt     <= cnt + CW'(1);
                            pending <= (s_in != act);
                        end
                        if (cnt == half) begin
                            preb <= 1'b1;
                            vclk <= 1'b0;
                        end
                    end
                end
            end

            assign sel_act[2*i +: 2] = act;
            assign vclk_o[i]  = vclk;
            assign cen_lo[i]  = pre & cen;
            assign cenb_lo[i] = preb & cen;
            assign cen_mid[i] = (pre | preb) & cen;
        end
    endgenerate

endmodule

// File: tb/tb_jt5205_timing_mc.sv
// Self-checking bench for jt5205_timing_mc.
// Two instances share clk/rst_n/cen/sync: a 2-channel one with default rates
// and a 1-channel one with LIM0=1. The reference model tracks, per channel,
// the cen-tick index where the current period started and derives every
// strobe from the distance to that origin.
module tb_jt5205_timing_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen;
    logic       sync;
    logic [3:0] sel;
    logic [1:0] sel_f;

    logic [3:0] sel_act;
    logic [1:0] cen_lo, cenb_lo, cen_mid, vclk_o;
    logic [1:0] f_act;
    logic [0:0] f_lo, f_lob, f_mid, f_vclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state; channel 2 is the LIM0=1 instance
    int         ck;
    int         m_start[3];
    logic [1:0] m_act[3];
    bit         m_pend[3];
    bit         m_lw[3];
    bit         m_lh[3];
    bit         m_vclk[3];
    logic [17:0] exp_all;

    jt5205_timing_mc #(.CH(2)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .sync(sync), .sel(sel),
        .sel_act(sel_act), .cen_lo(cen_lo), .cenb_lo(cenb_lo),
        .cen_mid(cen_mid), .vclk_o(vclk_o)
    );

    jt5205_timing_mc #(.CH(1), .LIM0(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .cen(cen), .sync(sync), .sel(sel_f),
        .sel_act(f_act), .cen_lo(f_lo), .cenb_lo(f_lob),
        .cen_mid(f_mid), .vclk_o(f_vclk)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    function automatic logic [1:0] cur_sel(int ch);
        if (ch == 2) return sel_f;
        return sel[2*ch +: 2];
    endfunction

    function automatic int lim_of(int ch, logic [1:0] code);
        case (code)
            2'd0:    return (ch == 2) ? 1 : 95;
            2'd1:    return 63;
            default: return 47;
        endcase
    endfunction

    function automatic logic [17:0] observed();
        return {f_act, sel_act, f_vclk, vclk_o, f_mid, cen_mid, f_lob, cenb_lo, f_lo, cen_lo};
    endfunction

    // Apply inputs for one cycle and form the expected outputs
    task automatic drive(input logic r, input logic c, input logic s,
                         input logic [3:0] sl, input logic [1:0] slf);
        logic [2:0] lo, lob, mid, vc;
        rst_n = r; cen = c; sync = s; sel = sl; sel_f = slf;
        #2;
        for (int ch = 0; ch < 3; ch++) begin
            lo[ch]  = m_lw[ch] & cen;
            lob[ch] = m_lh[ch] & cen;
            mid[ch] = (m_lw[ch] | m_lh[ch]) & cen;
            vc[ch]  = m_vclk[ch];
        end
        exp_all = {m_act[2], m_act[1], m_act[0], vc, mid, lob, lo};
    endtask

    // Clock edge: advance the reference model with the inputs the DUT saw
    task automatic advance();
        @(posedge clk);
        if (!rst_n) begin
            for (int ch = 0; ch < 3; ch++) begin
                m_act[ch] = cur_sel(ch); m_pend[ch] = 0; m_start[ch] = ck;
                m_lw[ch] = 0; m_lh[ch] = 0; m_vclk[ch] = 0;
            end
        end else if (sync) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (m_pend[ch]) m_act[ch] = cur_sel(ch);
                m_pend[ch] = 0; m_start[ch] = ck;
                m_lw[ch] = 0; m_lh[ch] = 0; m_vclk[ch] = 0;
            end
        end else if (cen) begin
            for (int ch = 0; ch < 3; ch++) begin
                int pos, lim;
                logic [1:0] s;
                s = cur_sel(ch);
                m_lw[ch] = 0; m_lh[ch] = 0;
                if (m_act[ch] == 2'd3) begin
                    m_vclk[ch] = 0; m_pend[ch] = 0;
                    m_act[ch] = s; m_start[ch] = ck + 1;
                end else begin
                    lim = lim_of(ch, m_act[ch]);
                    pos = ck - m_start[ch];
                    if (pos == lim) begin
                        m_lw[ch] = 1; m_vclk[ch] = 1; m_act[ch] = s;
                        m_pend[ch] = 0; m_start[ch] = ck + 1;
                    end else begin
                        m_pend[ch] = (s != m_act[ch]);
                    end
                    if (pos == lim / 2) begin
                        m_lh[ch] = 1; m_vclk[ch] = 0;
                    end
                end
            end
            ck++;
        end
        #1;
    endtask

    // Reset state: outputs low, sel_act follows sel, cen and sync ignored
    task automatic test_reset();
        drive(0, 1, 0, 4'b1001, 2'd1);
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'b1001, 2'd1);
            n_tests++;
            if (observed() !== exp_all) begin
                n_fail++;
                $display("[TB] FAIL reset_model k=%0d got %05h want %05h", k, observed(), exp_all);
            end
            n_tests++;
            if ({cen_mid, f_mid, vclk_o, f_vclk, cen_lo, cenb_lo} !== 10'd0 || sel_act !== 4'b1001) begin
                n_fail++;
                $display("[TB] FAIL reset_state got act=%b mid=%b vclk=%b want act=1001 all-zero", sel_act, cen_mid, vclk_o);
            end
            advance();
        end
    endtask

    // Steady rates: 96/64 clk periods, opposite-phase strobe at half period, LIM0=1 alternation
    task automatic test_rates();
        int last_lo[2];
        int n_per;
        last_lo[0] = -1; last_lo[1] = -1; n_per = 0;
        drive(0, 1, 0, 4'b0100, 2'd0);
        advance();
        for (int k = 0; k < 500; k++) begin
            drive(1, 1, 0, 4'b0100, 2'd0);
            n_tests++;
            if (observed() !== exp_all) begin
                n_fail++;
                $display("[TB] FAIL rates_model k=%0d got %05h want %05h", k, observed(), exp_all);
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (cenb_lo[ch] && last_lo[ch] >= 0) begin
                    n_tests++;
                    if (k - last_lo[ch] != (ch == 0 ? 48 : 32)) begin
                        n_fail++;
                        $display("[TB] FAIL rates_half ch%0d got %0d want %0d", ch, k - last_lo[ch], ch == 0 ? 48 : 32);
                    end
                end
                if (cen_lo[ch]) begin
                    if (last_lo[ch] >= 0) begin
                        n_tests++; n_per++;
                        if (k - last_lo[ch] != (ch == 0 ? 96 : 64)) begin
                            n_fail++;
                            $display("[TB] FAIL rates_period ch%0d got %0d want %0d", ch, k - last_lo[ch], ch == 0 ? 96 : 64);
                        end
                    end
                    last_lo[ch] = k;
                end
            end
            if (k >= 1) begin
                n_tests++;
                if (f_mid !== 1'b1 || (f_lo ^ f_lob) !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL fast_mid k=%0d got mid=%b lo=%b lob=%b want mid=1 alternating", k, f_mid, f_lo, f_lob);
                end
            end
            advance();
        end
        n_tests++;
        if (n_per < 8) begin
            n_fail++;
            $display("[TB] FAIL rates_count got %0d periods want >=8", n_per);
        end
    endtask

    // Rate change mid-period is deferred: 96-tick period finishes, then 48-tick periods
    task automatic test_rate_change();
        logic [3:0] sl;
        logic c;
        int phase, ct, a, chg;
        sl = 4'b0100; phase = 0; ct = 0; a = 0; chg = 0;
        drive(0, 1, 0, sl, 2'd0);
        advance();
        for (int k = 0; k < 4000 && phase < 4; k++) begin
            c = (k % 4 == 0);
            if (phase == 1 && c && ct - a == chg) begin
                sl = 4'b0110;
                phase = 2;
            end
            drive(1, c, 0, sl, 2'd0);
            n_tests++;
            if (observed() !== exp_all) begin
                n_fail++;
                $display("[TB] FAIL change_model k=%0d got %05h want %05h", k, observed(), exp_all);
            end
            if (cen_lo[0]) begin
                if (phase == 0) begin
                    a = ct; chg = $urandom_range(5, 80); phase = 1;
                end else if (phase == 2) begin
                    n_tests++;
                    if (ct - a != 96) begin
                        n_fail++;
                        $display("[TB] FAIL change_old_period got %0d want 96", ct - a);
                    end
                    a = ct; phase = 3;
                end else if (phase == 3) begin
                    n_tests++;
                    if (ct - a != 48) begin
                        n_fail++;
                        $display("[TB] FAIL change_new_period got %0d want 48", ct - a);
                    end
                    phase = 4;
                end
            end
            if (c) ct++;
            advance();
        end
        n_tests++;
        if (phase != 4) begin
            n_fail++;
            $display("[TB] FAIL change_timeout got phase %0d want 4", phase);
        end
    endtask

    // Stop via S=3 after the wrap, then restart with S=0
    task automatic test_stop();
        logic [3:0] sl;
        logic c;
        int phase, hold;
        bit ticked;
        sl = 4'b1001; phase = 0; hold = 0; ticked = 0;
        drive(0, 1, 0, sl, 2'd1);
        advance();
        for (int k = 0; k < 3000 && phase < 4; k++) begin
            c = 1'($urandom_range(0, 1));
            drive(1, c, 0, sl, 2'd1);
            n_tests++;
            if (observed() !== exp_all) begin
                n_fail++;
                $display("[TB] FAIL stop_model k=%0d got %05h want %05h", k, observed(), exp_all);
            end
            case (phase)
                0: if (cen_lo[0]) begin sl = 4'b1011; phase = 1; end
                1: if (sel_act[1:0] == 2'd3) phase = 2;
                2: begin
                    if (ticked) begin
                        n_tests++;
                        if (vclk_o[0] !== 1'b0 || cen_lo[0] !== 1'b0 || cenb_lo[0] !== 1'b0) begin
                            n_fail++;
                            $display("[TB] FAIL stopped_quiet got vclk=%b lo=%b lob=%b want 0", vclk_o[0], cen_lo[0], cenb_lo[0]);
                        end
                    end
                    if (c) ticked = 1;
                    hold++;
                    if (hold == 40) begin sl = 4'b1000; phase = 3; end
                end
                default: if (cen_lo[0] && sel_act[1:0] == 2'd0) phase = 4;
            endcase
            advance();
        end
        n_tests++;
        if (phase != 4) begin
            n_fail++;
            $display("[TB] FAIL stop_timeout got phase %0d want 4", phase);
        end
    endtask

    // Sync realigns out-of-phase channels and applies a pending code at once
    task automatic test_sync();
        logic [3:0] sl;
        int n1, n_lo;
        sl = 4'b1101; n_lo = 0;
        drive(0, 1, 0, sl, 2'd0);
        advance();
        n1 = $urandom_range(20, 60);
        for (int k = 0; k < n1; k++) begin
            drive(1, 1, 0, sl, 2'd0); advance();
        end
        sl = 4'b0101;
        n1 = $urandom_range(30, 150);
        for (int k = 0; k < n1; k++) begin
            drive(1, 1'($urandom_range(0, 1)), 0, sl, 2'd0);
            n_tests++;
            if (observed() !== exp_all) begin
                n_fail++;
                $display("[TB] FAIL sync_model k=%0d got %05h want %05h", k, observed(), exp_all);
            end
            advance();
        end
        drive(1, 1, 0, sl, 2'd2); advance();
        drive(1, 1, 1, sl, 2'd2); advance();
        for (int k = 0; k < 300; k++) begin
            drive(1, 1, 0, sl, 2'd2);
            n_tests++;
            if (observed() !== exp_all) begin
                n_fail++;
                $display("[TB] FAIL sync_after k=%0d got %05h want %05h", k, observed(), exp_all);
            end
            if (k == 0) begin
                n_tests++;
                if ({f_vclk, vclk_o} !== 3'b000 || f_act !== 2'd2) begin
                    n_fail++;
                    $display("[TB] FAIL sync_state got vclk=%b%b act_f=%0d want 000 and 2", f_vclk, vclk_o, f_act);
                end
            end
            n_tests++;
            if (cen_lo[0] !== cen_lo[1]) begin
                n_fail++;
                $display("[TB] FAIL sync_align k=%0d got lo=%b want equal bits", k, cen_lo);
            end
            if (cen_lo[0]) n_lo++;
            advance();
        end
        n_tests++;
        if (n_lo < 2) begin
            n_fail++;
            $display("[TB] FAIL sync_strobes got %0d want >=2", n_lo);
        end
    endtask

    // Reset in the middle of a period, then counting from zero
    task automatic test_reset_mid();
        logic [3:0] sl;
        int f0, f1;
        sl = 4'b0110; f0 = -1; f1 = -1;
        for (int k = 0; k < 40; k++) begin
            drive(1, 1'($urandom_range(0, 1)), 0, sl, 2'd1); advance();
        end
        sl = 4'b1001;
        drive(0, 1, 0, sl, 2'd1); advance();
        drive(0, 1, 0, sl, 2'd1);
        n_tests++;
        if ({cen_lo, cenb_lo, cen_mid, vclk_o} !== 8'd0 || sel_act !== 4'b1001) begin
            n_fail++;
            $display("[TB] FAIL reset_mid got act=%b lo=%b vclk=%b want 1001 and zeros", sel_act, cen_lo, vclk_o);
        end
        advance();
        for (int k = 0; k < 150; k++) begin
            drive(1, 1, 0, sl, 2'd1);
            n_tests++;
            if (observed() !== exp_all) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_model k=%0d got %05h want %05h", k, observed(), exp_all);
            end
            if (cen_lo[0] && f0 < 0) f0 = k;
            if (cen_lo[1] && f1 < 0) f1 = k;
            advance();
        end
        n_tests++;
        if (f0 != 64 || f1 != 48) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_first got ch0=%0d ch1=%0d want 64 48", f0, f1);
        end
    endtask

    // Random codes, cen, sync and reset against the model
    task automatic test_random();
        logic [3:0] sl;
        logic [1:0] slf;
        logic r, c, s;
        sl = 4'b0100; slf = 2'd0;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 49) == 0) sl[1:0] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) sl[3:2] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) slf = 2'($urandom_range(0, 3));
            r = ($urandom_range(0, 399) != 0);
            s = ($urandom_range(0, 99) == 0);
            c = ($urandom_range(0, 3) != 0);
            drive(r, c, s, sl, slf);
            n_tests++;
            if (observed() !== exp_all) begin
                n_fail++;
                $display("[TB] FAIL random_model k=%0d got %05h want %05h", k, observed(), exp_all);
            end
            advance();
        end
    endtask

    initial begin
        ck = 0;
        for (int ch = 0; ch < 3; ch++) begin
            m_start[ch] = 0; m_act[ch] = 2'd0; m_pend[ch] = 0;
            m_lw[ch] = 0; m_lh[ch] = 0; m_vclk[ch] = 0;
        end
        rst_n = 1'b0; cen = 1'b0; sync = 1'b0; sel = 4'd0; sel_f = 2'd0;
        test_reset();
        test_rates();
        test_rate_change();
        test_stop();
        test_sync();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
